// File: rtl/add_sub_pipe.sv
// ============================================================================
// add_sub_pipe : pipelined two's-complement adder/subtractor, W bits per stage
// Optional macro ADD_SUB_SAT_EN saturates S on signed overflow.
// Revision: 1.0
// ============================================================================
`default_nettype none

module add_sub_pipe #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Sel,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] S,
  output logic         Co,
  output logic         Ov,
  output logic         Z,
  output logic         Neg,
  output logic         Sat,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int L = N / W;

  // w_*[k] are the operands presented to stage k this cycle.
  logic [N-1:0] w_a [L];
  logic [N-1:0] w_b [L];
  logic [N-1:0] w_r [L];
  logic [L-1:0] w_c;
  logic [L-1:0] w_v;

  logic         w_adv;
  logic [N-1:0] w_s_fin;
  logic         w_co_fin;
  logic         w_ov_fin;
  logic         w_sat_fin;
  logic         w_v_fin;

  logic [N-1:0] s_q;
  logic         co_q;
  logic         ov_q;
  logic         z_q;
  logic         neg_q;
  logic         valid_q;

  // Global enable: the whole pipeline moves or the whole pipeline holds.
  assign w_adv    = !valid_q || out_ready;
  assign in_ready = w_adv;

  assign w_a[0] = A;
  assign w_b[0] = Sel ? ~B : B;
  assign w_r[0] = '0;
  assign w_c[0] = Sel;
  assign w_v[0] = in_valid;

  genvar gk;
  for (gk = 0; gk < L; gk++) begin : g_stage
    localparam int LO = gk * W;

    logic [W:0]   w_sum;
    logic [N-1:0] w_r_new;

    assign w_sum = {1'b0, w_a[gk][LO +: W]} + {1'b0, w_b[gk][LO +: W]}
                 + {{W{1'b0}}, w_c[gk]};

    always_comb begin
      w_r_new          = w_r[gk];
      w_r_new[LO +: W] = w_sum[W-1:0];
    end

    if (gk < L - 1) begin : g_mid
      logic [N-1:0] a_q;
      logic [N-1:0] b_q;
      logic [N-1:0] r_q;
      logic         c_q;
      logic         v_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
          r_q <= '0;
          c_q <= 1'b0;
          v_q <= 1'b0;
        end else if (w_adv) begin
          a_q <= w_a[gk];
          b_q <= w_b[gk];
          r_q <= w_r_new;
          c_q <= w_sum[W];
          v_q <= w_v[gk];
        end
      end

      assign w_a[gk+1] = a_q;
      assign w_b[gk+1] = b_q;
      assign w_r[gk+1] = r_q;
      assign w_c[gk+1] = c_q;
      assign w_v[gk+1] = v_q;
    end else begin : g_last
      logic w_ov;

      // Carry into the MSB is a^b^s at bit N-1, so Ov needs no extra chain tap.
      assign w_ov     = w_a[gk][N-1] ^ w_b[gk][N-1] ^ w_r_new[N-1] ^ w_sum[W];
      assign w_co_fin = w_sum[W];
      assign w_ov_fin = w_ov;
      assign w_v_fin  = w_v[gk];

`ifdef ADD_SUB_SAT_EN
      always_comb begin
        w_s_fin   = w_r_new;
        w_sat_fin = 1'b0;
        if (w_ov) begin
          w_sat_fin = 1'b1;
          w_s_fin   = w_a[gk][N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end
      end
`else
      assign w_s_fin   = w_r_new;
      assign w_sat_fin = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q     <= '0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
      z_q     <= 1'b0;
      neg_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (w_adv) begin
      s_q     <= w_s_fin;
      co_q    <= w_co_fin;
      ov_q    <= w_ov_fin;
      z_q     <= (w_s_fin == '0);
      neg_q   <= w_s_fin[N-1];
      valid_q <= w_v_fin;
    end
  end

`ifdef ADD_SUB_SAT_EN
  logic sat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
    end else if (w_adv) begin
      sat_q <= w_sat_fin;
    end
  end

  assign Sat = sat_q;
`else
  logic w_sat_unused;
  assign w_sat_unused = w_sat_fin;
  assign Sat          = 1'b0;
`endif

  assign S         = s_q;
  assign Co        = co_q;
  assign Ov        = ov_q;
  assign Z         = z_q;
  assign Neg       = neg_q;
  assign out_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_add_sub_pipe.sv
// ============================================================================
// tb_add_sub_pipe : scoreboard bench for add_sub_pipe at N16/W4, N8/W8, N32/W4
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_add_sub_pipe;

  typedef struct packed {
    logic [31:0] s;
    logic        co;
    logic        ov;
    logic        z;
    logic        neg;
    logic        sat;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a_drv;
  logic [31:0] b_drv;
  logic        sel_drv;
  logic        out_rdy;
  logic [2:0]  iv;
  logic [2:0]  ir, co, ov, z, ng, st, vo;
  logic [15:0] s16;
  logic [7:0]  s8;
  logic [31:0] s32;
  int          cur;
  res_t        obs;
  res_t        q[$];
  int          checks;
  int          failures;

  always #5 clk = ~clk;

  // index 0: N=16/W=4, index 1: N=8/W=8, index 2: N=32/W=4
  add_sub_pipe #(.N(16), .W(4)) u16 (
    .clk(clk), .rst_n(rst_n), .A(a_drv[15:0]), .B(b_drv[15:0]), .Sel(sel_drv),
    .in_valid(iv[0]), .in_ready(ir[0]), .S(s16), .Co(co[0]), .Ov(ov[0]),
    .Z(z[0]), .Neg(ng[0]), .Sat(st[0]), .out_valid(vo[0]), .out_ready(out_rdy));

  add_sub_pipe #(.N(8), .W(8)) u8 (
    .clk(clk), .rst_n(rst_n), .A(a_drv[7:0]), .B(b_drv[7:0]), .Sel(sel_drv),
    .in_valid(iv[1]), .in_ready(ir[1]), .S(s8), .Co(co[1]), .Ov(ov[1]),
    .Z(z[1]), .Neg(ng[1]), .Sat(st[1]), .out_valid(vo[1]), .out_ready(out_rdy));

  add_sub_pipe #(.N(32), .W(4)) u32 (
    .clk(clk), .rst_n(rst_n), .A(a_drv), .B(b_drv), .Sel(sel_drv),
    .in_valid(iv[2]), .in_ready(ir[2]), .S(s32), .Co(co[2]), .Ov(ov[2]),
    .Z(z[2]), .Neg(ng[2]), .Sat(st[2]), .out_valid(vo[2]), .out_ready(out_rdy));

  always_comb begin
    obs = '0;
    case (cur)
      1:       obs.s = {24'd0, s8};
      2:       obs.s = s32;
      default: obs.s = {16'd0, s16};
    endcase
    obs.co  = co[cur];
    obs.ov  = ov[cur];
    obs.z   = z[cur];
    obs.neg = ng[cur];
    obs.sat = st[cur];
  end

  // Reference: true signed result decides overflow and saturation direction.
  function automatic res_t model(int n, logic [31:0] a, logic [31:0] b, logic sel);
    res_t   r;
    longint mask, half, ua, ub, sa, sb, tr, raw;
    mask = (longint'(1) << n) - 1;
    half = longint'(1) << (n - 1);
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    sa   = (ua >= half) ? ua - (mask + 1) : ua;
    sb   = (ub >= half) ? ub - (mask + 1) : ub;
    tr   = sel ? sa - sb : sa + sb;
    raw  = sel ? ua + ((~ub) & mask) + 1 : ua + ub;
    r    = '0;
    r.s  = 32'(raw & mask);
    r.co = ((raw >> n) & 1) != 0;
    r.ov = (tr > half - 1) || (tr < -half);
`ifdef ADD_SUB_SAT_EN
    if (r.ov) begin
      r.sat = 1'b1;
      r.s   = 32'((tr > 0) ? half - 1 : half);
    end
`endif
    r.z   = (r.s == 32'd0);
    r.neg = r.s[n-1];
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; iv = '0; out_rdy = 1'b1; a_drv = '0; b_drv = '0; sel_drv = 1'b0; cur = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (vo !== 3'b000) begin
      failures++; $display("FAIL reset_valid got=%b exp=000", vo);
    end
    checks++;
    if ({s16, co[0], ov[0], z[0], ng[0], st[0]} !== 21'd0 || s8 !== 8'd0 || s32 !== 32'd0) begin
      failures++; $display("FAIL reset_outputs s16=%h s8=%h s32=%h flags=%b exp=0", s16, s8, s32,
                           {co[0], ov[0], z[0], ng[0], st[0]});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (ir !== 3'b111 || vo !== 3'b000) begin
      failures++; $display("FAIL reset_release in_ready=%b out_valid=%b exp=111/000", ir, vo);
    end
  endtask

  task automatic test_corners();
    int        n, lexp, lat;
    bit        got;
    longint    mp, mn, ones;
    logic [31:0] ca[5], cb[5];
    logic      cs[5];
    res_t      exp;
    out_rdy = 1'b1;
    for (int idx = 0; idx < 3; idx++) begin
      n    = (idx == 0) ? 16 : (idx == 1) ? 8 : 32;
      lexp = (idx == 0) ? 4  : (idx == 1) ? 1 : 8;
      mp   = (longint'(1) << (n - 1)) - 1;
      mn   = longint'(1) << (n - 1);
      ones = (longint'(1) << n) - 1;
      ca[0] = 32'(mp);   cb[0] = 32'd1; cs[0] = 1'b0;
      ca[1] = 32'd5;     cb[1] = 32'd5; cs[1] = 1'b1;
      ca[2] = 32'd0;     cb[2] = 32'd1; cs[2] = 1'b1;
      ca[3] = 32'(ones); cb[3] = 32'd1; cs[3] = 1'b0;
      ca[4] = 32'(mn);   cb[4] = 32'd1; cs[4] = 1'b1;
      for (int c = 0; c < 5; c++) begin
        @(posedge clk);
        #1;
        cur = idx; a_drv = ca[c]; b_drv = cb[c]; sel_drv = cs[c]; iv[idx] = 1'b1;
        exp = model(n, ca[c], cb[c], cs[c]);
        @(posedge clk);
        lat = 1;
        #1 iv[idx] = 1'b0;
        got = 1'b0;
        while (lat < 50) begin
          @(negedge clk);
          if (vo[idx]) begin
            got = 1'b1;
            break;
          end
          @(posedge clk);
          lat++;
        end
        checks++;
        if (!got || lat != lexp) begin
          failures++; $display("FAIL latency n=%0d case=%0d got=%0d exp=%0d", n, c, lat, lexp);
        end
        checks++;
        if (obs !== exp) begin
          failures++;
          $display("FAIL corner n=%0d case=%0d got S=%h C=%b V=%b Z=%b N=%b Sat=%b exp S=%h C=%b V=%b Z=%b N=%b Sat=%b",
                   n, c, obs.s, obs.co, obs.ov, obs.z, obs.neg, obs.sat,
                   exp.s, exp.co, exp.ov, exp.z, exp.neg, exp.sat);
        end
      end
    end
  endtask

  task automatic test_stream();
    int   acc, rcv, cyc;
    bit   accept, stall_prev;
    res_t prev, exp;
    acc = 0; rcv = 0; cyc = 0; stall_prev = 1'b0; prev = '0;
    cur = 0; q.delete();
    @(posedge clk);
    #1;
    iv[0] = 1'b1; a_drv = $urandom; b_drv = $urandom; sel_drv = 1'($urandom % 2);
    out_rdy = 1'($urandom % 2);
    while (rcv < 10 && cyc < 300) begin
      @(negedge clk);
      checks++;
      if (ir[0] !== (!vo[0] || out_rdy)) begin
        failures++; $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, ir[0], !vo[0] || out_rdy);
      end
      if (stall_prev) begin
        checks++;
        if (vo[0] !== 1'b1 || obs !== prev) begin
          failures++; $display("FAIL stall_hold cyc=%0d got S=%h v=%b exp S=%h v=1", cyc, obs.s, vo[0], prev.s);
        end
      end
      if (vo[0] && out_rdy) begin
        checks++;
        if (q.size() == 0) begin
          failures++; $display("FAIL stream_extra cyc=%0d got S=%h exp none", cyc, obs.s);
        end else begin
          exp = q.pop_front();
          if (obs !== exp) begin
            failures++;
            $display("FAIL stream_result #%0d got S=%h flags=%b exp S=%h flags=%b", rcv, obs.s,
                     {obs.co, obs.ov, obs.z, obs.neg, obs.sat}, exp.s, {exp.co, exp.ov, exp.z, exp.neg, exp.sat});
          end
        end
        rcv++;
      end
      accept = iv[0] && ir[0];
      if (accept) begin
        q.push_back(model(16, a_drv, b_drv, sel_drv));
        acc++;
      end
      stall_prev = vo[0] && !out_rdy;
      prev       = obs;
      @(posedge clk);
      #1;
      cyc++;
      if (accept) begin
        if (acc < 10) begin
          a_drv = $urandom; b_drv = $urandom; sel_drv = 1'($urandom % 2);
        end else begin
          iv[0] = 1'b0;
        end
      end
      out_rdy = (cyc >= 6 && cyc < 11) ? 1'b0 : 1'($urandom % 2);
    end
    checks++;
    if (acc != 10 || rcv != 10 || q.size() != 0) begin
      failures++; $display("FAIL stream_count got acc=%0d rcv=%0d left=%0d exp 10/10/0", acc, rcv, q.size());
    end
    iv[0] = 1'b0; out_rdy = 1'b1;
  endtask

  task automatic test_back_to_back();
    int   issued, rcv, first, last;
    res_t exp;
    cur = 0; out_rdy = 1'b1; q.delete();
    issued = 0; rcv = 0; first = -1; last = -1;
    @(posedge clk);
    #1;
    iv[0] = 1'b1; a_drv = 32'h0000_1234; b_drv = 32'h0000_0F0F; sel_drv = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (vo[0]) begin
        checks++;
        exp = (q.size() != 0) ? q.pop_front() : '0;
        if (obs !== exp) begin
          failures++; $display("FAIL b2b_result #%0d got S=%h exp S=%h", rcv, obs.s, exp.s);
        end
        if (first < 0) first = c;
        last = c;
        rcv++;
      end
      if (iv[0] && ir[0]) begin
        q.push_back(model(16, a_drv, b_drv, sel_drv));
        issued++;
      end
      @(posedge clk);
      #1;
      if (issued < 4) begin
        a_drv = a_drv + 32'h0000_2111; sel_drv = ~sel_drv;
      end else begin
        iv[0] = 1'b0;
      end
    end
    checks++;
    if (rcv != 4 || last - first != 3) begin
      failures++; $display("FAIL b2b_throughput got rcv=%0d span=%0d exp 4/3", rcv, last - first);
    end
  endtask

  task automatic test_mid_reset();
    bit stale;
    cur = 0; out_rdy = 1'b1; iv = '0;
    a_drv = 32'h0000_1111; b_drv = 32'h0000_2222; sel_drv = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    iv[0] = 1'b1; a_drv = 32'h0000_1234; b_drv = 32'h0000_1111;
    @(posedge clk);
    #1 a_drv = 32'h0000_7000; b_drv = 32'h0000_0123; sel_drv = 1'b1;
    @(posedge clk);
    #1 a_drv = 32'h0000_ABCD; b_drv = 32'h0000_0042; sel_drv = 1'b0;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (vo[0] !== 1'b0 || {s16, co[0], ov[0], z[0], ng[0], st[0]} !== 21'd0) begin
      failures++; $display("FAIL midreset_clear got v=%b S=%h flags=%b exp 0", vo[0], s16,
                           {co[0], ov[0], z[0], ng[0], st[0]});
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ir[0] !== 1'b1) begin
      failures++; $display("FAIL midreset_ready got=%b exp=1", ir[0]);
    end
    stale = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (vo[0] !== 1'b0) stale = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (stale) begin
      failures++; $display("FAIL midreset_stale got out_valid=1 exp=0");
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    test_reset();
    test_corners();
    test_stream();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
